// File: rtl/spi_pkg.sv
// Shared FSM state encoding and default widths for the SPI serial-clock generator.
package spi_pkg;
  localparam int C_DIV_WIDTH = 8;
  localparam int C_NB_WIDTH  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } spi_state_e;
endpackage

// File: rtl/spi_div_cnt.sv
// Half-period down-counter: load to a value, count to zero, hold at zero; tc_o flags zero.
module spi_div_cnt
  import spi_pkg::*;
#(
  parameter int G_W = C_DIV_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic [G_W-1:0] load_val_i,
  output logic           tc_o
);
  logic [G_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/spi_sclk_gen.sv
// SPI SCLK generator: IDLE -> RUN (2N edges) -> TAIL (one half period) -> IDLE, with
// load/sample/shift strobes aligned to the cycle sclk shows its new level.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int G_DIV_WIDTH = C_DIV_WIDTH,
  parameter int G_NB_WIDTH  = C_NB_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic [G_DIV_WIDTH-1:0] clk_div,
  input  logic [G_NB_WIDTH-1:0]  nb_bits,
  output logic                   sclk,
  output logic                   load_pulse,
  output logic                   sample_pulse,
  output logic                   shift_pulse,
  output logic                   busy,
  output logic                   done
);
  spi_state_e             state_q;
  logic                   cpol_q, cpha_q;
  logic [G_DIV_WIDTH-1:0] div_q;
  // One extra bit so 2N is representable at the largest nb_bits.
  logic [G_NB_WIDTH:0]    two_n_q, edge_q, edge_nxt;
  logic                   sclk_q, load_q, samp_q, shift_q, busy_q, done_q;
  logic                   tc, accept, cnt_load;
  logic [G_DIV_WIDTH-1:0] cnt_load_val;

  assign accept       = (state_q == ST_IDLE) && start && (nb_bits != '0);
  assign cnt_load     = accept || ((state_q == ST_RUN) && tc);
  assign cnt_load_val = accept ? clk_div : div_q;
  assign edge_nxt     = edge_q + 1'b1;

  spi_div_cnt #(.G_W(G_DIV_WIDTH)) u_div_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .tc_o       (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      two_n_q <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      load_q  <= 1'b0;
      samp_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      load_q  <= 1'b0;
      samp_q  <= 1'b0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          sclk_q <= cpol;
          busy_q <= 1'b0;
          if (accept) begin
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            div_q   <= clk_div;
            two_n_q <= {nb_bits, 1'b0};
            edge_q  <= '0;
            busy_q  <= 1'b1;
            load_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tc) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_nxt;
            if (edge_nxt[0]) begin
              if (cpha_q) shift_q <= 1'b1;
              else        samp_q  <= 1'b1;
            end else begin
              // Leading-edge sampling has no shift after the final edge.
              if (cpha_q)                    samp_q  <= 1'b1;
              else if (edge_nxt != two_n_q)  shift_q <= 1'b1;
            end
            if (edge_nxt == two_n_q) state_q <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          sclk_q <= cpol_q;
          if (tc) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sclk         = sclk_q;
  assign load_pulse   = load_q;
  assign sample_pulse = samp_q;
  assign shift_pulse  = shift_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule
